// File: rtl/vid_sram_reader.sv
// vid_sram_reader
//   Read engine for the vid SRAM. On start it reads num_batch consecutive words
//   from start_addr and emits each word as Q vids on a valid/ready stream. The
//   stream starts with lane 0, which is the least significant bits of the word.
//   The engine drives raddr and absorbs the SRAM's 1-cycle registered read latency.
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   start                  1-cycle job request, sampled only in IDLE
//   start_addr, num_batch  job parameters, latched on an accepted start
//   raddr / rdata          SRAM read address (registered) / read data (1 cycle later)
//   vid_out, vid_valid     vid stream toward downstream; vid_ready is the back-pressure
//   vid_last               marks the final vid of the job
//   busy, done             engine active / 1-cycle job completion pulse
module vid_sram_reader #(
    parameter int unsigned ADDR_SPACE = 4,
    parameter int unsigned Q          = 16,
    parameter int unsigned VID_BW     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_SPACE-1:0]   start_addr,
    input  logic [ADDR_SPACE:0]     num_batch,
    output logic [ADDR_SPACE-1:0]   raddr,
    input  logic [VID_BW*Q-1:0]     rdata,
    output logic [VID_BW-1:0]       vid_out,
    output logic                    vid_valid,
    input  logic                    vid_ready,
    output logic                    vid_last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W  = ADDR_SPACE + 1;
    localparam int unsigned LANE_W = (Q > 1) ? $clog2(Q) : 1;
    localparam int unsigned WORD_W = VID_BW * Q;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_SPACE-1:0]   raddr_nxt;
    logic [LANE_W-1:0]       lane, lane_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [CNT_W-1:0]        nb_q, nb_nxt;
    logic [WORD_W-1:0]       word_q, word_nxt;
    logic [VID_BW-1:0]       vid_out_nxt;
    logic                    vid_valid_nxt, vid_last_nxt, busy_nxt, done_nxt;
    logic                    lane_end, word_end;

    assign lane_end = (lane == LANE_W'(Q - 1));
    assign word_end = (cnt == nb_q - CNT_W'(1));

    // Next-state and next-output logic; outputs are registered from the *_nxt values.
    always_comb begin
        state_nxt = state;
        raddr_nxt = raddr;
        lane_nxt  = lane;
        cnt_nxt   = cnt;
        nb_nxt    = nb_q;
        word_nxt  = word_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    nb_nxt    = num_batch;
                    raddr_nxt = start_addr;
                    cnt_nxt   = '0;
                    lane_nxt  = '0;
                    state_nxt = (num_batch == '0) ? DONE : REQ;
                end
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                word_nxt  = rdata;
                lane_nxt  = '0;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (vid_ready) begin
                    if (!lane_end) begin
                        lane_nxt = lane + LANE_W'(1);
                    end else if (word_end) begin
                        state_nxt = DONE;
                    end else begin
                        raddr_nxt = raddr + ADDR_SPACE'(1);
                        cnt_nxt   = cnt + CNT_W'(1);
                        state_nxt = REQ;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        vid_valid_nxt = (state_nxt == STREAM);
        vid_out_nxt   = word_nxt[lane_nxt*VID_BW +: VID_BW];
        vid_last_nxt  = (state_nxt == STREAM) && (lane_nxt == LANE_W'(Q - 1))
                        && (cnt_nxt == nb_nxt - CNT_W'(1));
        busy_nxt      = (state_nxt != IDLE);
        done_nxt      = (state_nxt == DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            raddr     <= '0;
            lane      <= '0;
            cnt       <= '0;
            nb_q      <= '0;
            vid_out   <= '0;
            vid_valid <= 1'b0;
            vid_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            raddr     <= raddr_nxt;
            lane      <= lane_nxt;
            cnt       <= cnt_nxt;
            nb_q      <= nb_nxt;
            vid_out   <= vid_out_nxt;
            vid_valid <= vid_valid_nxt;
            vid_last  <= vid_last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Word buffer needs no reset; it is always loaded before being streamed.
    always_ff @(posedge clk) begin
        word_q <= word_nxt;
    end

endmodule
